fb_read_arbiter: RTL and testbench
==================================

Name: fb_read_arbiter

Overview:
- Shares the single read port of the 320x240 packed frame buffer (19200 words of 16 bits, four 4-bit pixels per word) among three requesters.
- Requester 0 is the VGA display fetch and has fixed priority. Requesters 1 and 2 are the X-gradient and Y-gradient engines; they alternate round-robin.
- A starvation guard lets a gradient engine pre-empt the display after a bounded wait.
- The block sits between the requesters and the frame-buffer BRAM. It drives the BRAM address and enable, and returns read data tagged with a per-requester valid.

Parameters:
- ADDR_W, 15, frame-buffer word address width.
- DATA_W, 16, frame-buffer word width.
- RD_LAT, 1, BRAM read latency in cycles (1..4).
- MAX_WAIT, 64, cycles a gradient requester may wait with req high before it pre-empts the display (2..255).

Ports:
- clk  in  1  reference clock; all logic is on its rising edge.
- rst  in  1  synchronous, active-high reset.
- req  in  3  read request per requester; bit 0 = display, bit 1 = X-gradient, bit 2 = Y-gradient.
- req_addr  in  3*ADDR_W  word addresses; requester i uses bits [i*ADDR_W +: ADDR_W].
- gnt  out  3  one-hot grant; combinational from req and registered state.
- rvalid  out  3  one-hot read-data valid, per requester.
- rdata  out  DATA_W  read data, broadcast to all requesters; qualified by rvalid.
- fb_en  out  1  BRAM read enable.
- fb_addr  out  ADDR_W  BRAM read address.
- fb_dout  in  DATA_W  BRAM read data, valid RD_LAT cycles after fb_en.
- starve_evt  out  1  one-cycle pulse when a starvation pre-emption is granted.

Behaviour:
- Requester contract:
  - A requester holds req[i] and its address stable until it sees gnt[i].
  - It may keep req[i] high for back-to-back reads, changing the address in the cycle after gnt.
- Grant rules:
  - At most one gnt bit is high per cycle.
  - fb_en = |gnt.
  - fb_addr = address of the granted requester; 0 when there is no grant.
- Priority order, evaluated each cycle:
  1. A starved gradient requester. If both are starved, requester 1 wins.
  2. Requester 0, the display.
  3. Round-robin between requesters 1 and 2.
- Round-robin:
  - rr_last (1 bit) records the gradient requester granted most recently.
  - When both 1 and 2 request, the one not equal to rr_last is granted.
  - rr_last updates only when requester 1 or 2 is granted.
  - rr_last resets to requester 2, so requester 1 wins first.
- Starvation counters:
  - There is one 8-bit counter per gradient requester.
  - The counter increments each cycle its req is high and its gnt is low, saturating at MAX_WAIT.
  - It clears on that requester's grant, or whenever its req is low.
  - A requester is starved when its counter equals MAX_WAIT.
  - A starved grant that displaces a concurrent req[0] pulses starve_evt in the same cycle.
- Read return:
  - A tag pipeline of depth RD_LAT carries the gnt vector.
  - rvalid equals the tag stage RD_LAT cycles after the grant.
  - rdata = fb_dout, passed through combinationally.
  - Throughput is one read per cycle, with any mix of requesters.
- No request: gnt = 0, fb_en = 0, and the tag pipeline shifts zeros.
- Reset values, and reset asserted mid-operation:
  - gnt = 0, fb_en = 0, fb_addr = 0, rvalid = 0, starve_evt = 0.
  - Counters = 0, rr_last = 2, tag pipeline cleared.
  - Reads in flight are dropped and produce no rvalid.
  - The first grant can occur in the cycle after rst deasserts.
- Simultaneous events:
  - A requester dropping req in the same cycle another raises it is arbitrated on current inputs only.
  - A grant and a counter saturation in the same cycle: the grant wins and the counter clears.
- Width rules:
  - Counters compare against MAX_WAIT truncated to 8 bits.
  - Addresses pass through unmodified; no range check is done (the legal range is 0..19199).

Test Plan:
- Single requester: req=3'b010, addr1=100 for 3 cycles -> gnt=3'b010 each cycle, fb_addr=100; rvalid=3'b010 one cycle later each time (RD_LAT=1); rdata=fb_dout.
- Display priority: req=3'b111 for one cycle -> gnt=3'b001, fb_addr=addr0; the counters for 1 and 2 each become 1.
- Round-robin: req=3'b110 held for 4 cycles after reset -> gnt sequence 010, 100, 010, 100.
- Starvation: MAX_WAIT=4, req=3'b011 held -> gnt=001 for 4 cycles, then gnt=010 with starve_evt=1 in cycle 5, then gnt=001 again.
- Latency: RD_LAT=3, grants to 0, 1, 2 on consecutive cycles -> rvalid 001, 010, 100 on cycles 3, 4 and 5 after the first grant; rdata matches BRAM words at addresses 0, 19199 and 80.
- Reset mid-operation: assert rst one cycle after a grant with RD_LAT=2 -> no rvalid for that read; all outputs 0; the next arbitration after rst deasserts grants requester 1 over requester 2.

Source files
------------

// File: rtl/fb_read_arbiter.sv
// fb_read_arbiter: shares the frame-buffer BRAM read port among the
// display fetch (fixed priority) and two gradient engines (round-robin).
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   req        per-requester read request (0 display, 1 X-grad, 2 Y-grad)
//   req_addr   packed word addresses, requester i at [i*ADDR_W +: ADDR_W]
//   gnt        one-hot grant, combinational
//   rvalid     one-hot read-data valid, RD_LAT cycles after the grant
//   rdata      read data broadcast to all requesters
//   fb_en      BRAM read enable
//   fb_addr    BRAM read address
//   fb_dout    BRAM read data
//   starve_evt pulse when a starved gradient engine displaces the display
module fb_read_arbiter #(
    parameter int ADDR_W   = 15,
    parameter int DATA_W   = 16,
    parameter int RD_LAT   = 1,
    parameter int MAX_WAIT = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [2:0]            req,
    input  logic [3*ADDR_W-1:0]   req_addr,
    output logic [2:0]            gnt,
    output logic [2:0]            rvalid,
    output logic [DATA_W-1:0]     rdata,
    output logic                  fb_en,
    output logic [ADDR_W-1:0]     fb_addr,
    input  logic [DATA_W-1:0]     fb_dout,
    output logic                  starve_evt
);

    localparam logic [7:0] MAX_W8 = 8'(MAX_WAIT);

    logic [7:0] cnt1_q;
    logic [7:0] cnt1_d;
    logic [7:0] cnt2_q;
    logic [7:0] cnt2_d;

    // 0: requester 1 granted last, 1: requester 2 granted last
    logic rr_last_q;
    logic rr_last_d;

    logic [RD_LAT-1:0][2:0] tag_q;
    logic [RD_LAT-1:0][2:0] tag_d;

    logic       starve1;
    logic       starve2;
    logic [2:0] gnt_c;

    // Wait counter: saturates at the limit, clears on grant or idle.
    function automatic logic [7:0] next_cnt(
        input logic       r,
        input logic       g,
        input logic [7:0] c
    );
        logic [7:0] n;
        n = c;
        if (!r || g) begin
            n = 8'd0;
        end else if (c != MAX_W8) begin
            n = c + 8'd1;
        end
        return n;
    endfunction

    // Starvation only counts while the engine is still asking.
    always_comb begin
        starve1 = req[1] && (cnt1_q == MAX_W8);
        starve2 = req[2] && (cnt2_q == MAX_W8);
    end

    always_comb begin
        gnt_c = 3'b000;
        if (rst) begin
            gnt_c = 3'b000;
        end else if (starve1) begin
            gnt_c = 3'b010;
        end else if (starve2) begin
            gnt_c = 3'b100;
        end else if (req[0]) begin
            gnt_c = 3'b001;
        end else if (req[1] && req[2]) begin
            gnt_c = rr_last_q ? 3'b010 : 3'b100;
        end else if (req[1]) begin
            gnt_c = 3'b010;
        end else if (req[2]) begin
            gnt_c = 3'b100;
        end
    end

    always_comb begin
        fb_addr = '0;
        unique case (1'b1)
            gnt_c[0]: fb_addr = req_addr[0*ADDR_W +: ADDR_W];
            gnt_c[1]: fb_addr = req_addr[1*ADDR_W +: ADDR_W];
            gnt_c[2]: fb_addr = req_addr[2*ADDR_W +: ADDR_W];
            default:  fb_addr = '0;
        endcase
    end

    always_comb begin
        gnt        = gnt_c;
        fb_en      = |gnt_c;
        starve_evt = !rst && req[0] && (starve1 || starve2);
        rvalid     = rst ? 3'b000 : tag_q[RD_LAT-1];
        rdata      = fb_dout;
    end

    always_comb begin
        cnt1_d    = next_cnt(req[1], gnt_c[1], cnt1_q);
        cnt2_d    = next_cnt(req[2], gnt_c[2], cnt2_q);
        rr_last_d = rr_last_q;
        if (gnt_c[1]) begin
            rr_last_d = 1'b0;
        end else if (gnt_c[2]) begin
            rr_last_d = 1'b1;
        end
    end

    always_comb begin
        tag_d    = tag_q;
        tag_d[0] = gnt_c;
        for (int i = 1; i < RD_LAT; i++) begin
            tag_d[i] = tag_q[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt1_q    <= 8'd0;
            cnt2_q    <= 8'd0;
            rr_last_q <= 1'b1;
            tag_q     <= '0;
        end else begin
            cnt1_q    <= cnt1_d;
            cnt2_q    <= cnt2_d;
            rr_last_q <= rr_last_d;
            tag_q     <= tag_d;
        end
    end

endmodule

// File: tb/tb_fb_read_arbiter.sv
// tb_fb_read_arbiter: directed vector table plus randomized traffic
// against a queue-based reference model of the read arbiter.
module tb_fb_read_arbiter;

    localparam int AW  = 15;
    localparam int DW  = 16;
    localparam int LAT = 2;
    localparam int MW  = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic [2:0]       req;
    logic [3*AW-1:0]  req_addr;
    logic [2:0]       gnt;
    logic [2:0]       rvalid;
    logic [DW-1:0]    rdata;
    logic             fb_en;
    logic [AW-1:0]    fb_addr;
    logic [DW-1:0]    fb_dout;
    logic             starve_evt;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    fb_read_arbiter #(
        .ADDR_W(AW),
        .DATA_W(DW),
        .RD_LAT(LAT),
        .MAX_WAIT(MW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .req(req),
        .req_addr(req_addr),
        .gnt(gnt),
        .rvalid(rvalid),
        .rdata(rdata),
        .fb_en(fb_en),
        .fb_addr(fb_addr),
        .fb_dout(fb_dout),
        .starve_evt(starve_evt)
    );

    function automatic logic [DW-1:0] word(input int a);
        return DW'(a * 37 + 'h1357);
    endfunction

    // BRAM stand-in with LAT cycles of read latency
    logic [DW-1:0] bp [LAT];
    always @(posedge clk) begin
        bp[0] <= fb_en ? word(int'(fb_addr)) : '0;
        for (int k = 1; k < LAT; k++) bp[k] <= bp[k-1];
    end
    assign fb_dout = bp[LAT-1];

    // ---------------- reference model ----------------
    int w1, w2, last;
    int pq_who[$];
    int pq_addr[$];

    task automatic m_reset();
        w1 = 0;
        w2 = 0;
        last = 2;
        pq_who = {};
        pq_addr = {};
        for (int k = 0; k < LAT; k++) begin
            pq_who.push_back(-1);
            pq_addr.push_back(0);
        end
    endtask

    function automatic int addr_of(input int i);
        return int'(req_addr[i*AW +: AW]);
    endfunction

    task automatic m_pick(output int who, output bit stv);
        bit s1;
        bit s2;
        s1 = req[1] && (w1 == MW);
        s2 = req[2] && (w2 == MW);
        who = -1;
        if (rst) who = -1;
        else if (s1) who = 1;
        else if (s2) who = 2;
        else if (req[0]) who = 0;
        else if (req[1] && req[2]) who = (last == 1) ? 2 : 1;
        else if (req[1]) who = 1;
        else if (req[2]) who = 2;
        stv = !rst && req[0] && (s1 || s2);
    endtask

    task automatic m_advance(input int who);
        if (rst) begin
            m_reset();
        end else begin
            if (!req[1] || who == 1) w1 = 0;
            else if (w1 < MW) w1++;
            if (!req[2] || who == 2) w2 = 0;
            else if (w2 < MW) w2++;
            if (who == 1) last = 1;
            if (who == 2) last = 2;
            void'(pq_who.pop_front());
            void'(pq_addr.pop_front());
            pq_who.push_back(who);
            pq_addr.push_back(who < 0 ? 0 : addr_of(who));
        end
    endtask

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at t=%0t",
                     nm, act, exp, $time);
        end
    endtask

    // Compare all outputs against the model; call after negedge.
    task automatic model_check(output int who);
        bit       stv;
        int       front;
        logic [2:0] eg;
        logic [2:0] er;
        m_pick(who, stv);
        eg = (who < 0) ? 3'b000 : 3'(1 << who);
        front = rst ? -1 : pq_who[0];
        er = (front < 0) ? 3'b000 : 3'(1 << front);
        chk("m_gnt", 32'(gnt), 32'(eg));
        chk("m_fb_en", 32'(fb_en), 32'(who >= 0));
        chk("m_fb_addr", 32'(fb_addr), (who < 0) ? 0 : addr_of(who));
        chk("m_starve", 32'(starve_evt), 32'(stv));
        chk("m_rvalid", 32'(rvalid), 32'(er));
        if (front >= 0) chk("m_rdata", 32'(rdata), 32'(word(pq_addr[0])));
    endtask

    task automatic set_in(input bit r, input logic [2:0] q,
                          input int a0, input int a1, input int a2);
        rst = r;
        req = q;
        req_addr = {AW'(a2), AW'(a1), AW'(a0)};
    endtask

    task automatic step();
        int who;
        @(negedge clk);
        model_check(who);
        @(posedge clk);
        m_advance(who);
        #1;
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        bit         rst;
        logic [2:0] req;
        int         a0;
        int         a1;
        int         a2;
        logic [2:0] g;
        bit         s;
        logic [2:0] r;
    } vec_t;

    vec_t tv[$];

    function automatic vec_t mk(bit r, logic [2:0] q, int a0, int a1,
                                int a2, logic [2:0] g, bit s,
                                logic [2:0] rv);
        vec_t v;
        v.rst = r; v.req = q; v.a0 = a0; v.a1 = a1; v.a2 = a2;
        v.g = g; v.s = s; v.r = rv;
        return v;
    endfunction

    initial begin
        // reset, single requester, display priority
        tv.push_back(mk(1, 3'b111, 0, 0, 0, 3'b000, 0, 3'b000));
        tv.push_back(mk(0, 3'b010, 0, 100, 0, 3'b010, 0, 3'b000));
        tv.push_back(mk(0, 3'b010, 0, 100, 0, 3'b010, 0, 3'b000));
        tv.push_back(mk(0, 3'b010, 0, 100, 0, 3'b010, 0, 3'b010));
        tv.push_back(mk(0, 3'b000, 0, 0, 0, 3'b000, 0, 3'b010));
        tv.push_back(mk(0, 3'b111, 5, 6, 7, 3'b001, 0, 3'b010));
        tv.push_back(mk(0, 3'b000, 0, 0, 0, 3'b000, 0, 3'b000));
        // reset drops the in-flight display read
        tv.push_back(mk(1, 3'b000, 0, 0, 0, 3'b000, 0, 3'b000));
        // round-robin from reset
        tv.push_back(mk(0, 3'b110, 0, 10, 20, 3'b010, 0, 3'b000));
        tv.push_back(mk(0, 3'b110, 0, 10, 20, 3'b100, 0, 3'b000));
        tv.push_back(mk(0, 3'b110, 0, 10, 20, 3'b010, 0, 3'b010));
        tv.push_back(mk(0, 3'b110, 0, 10, 20, 3'b100, 0, 3'b100));
        tv.push_back(mk(0, 3'b000, 0, 0, 0, 3'b000, 0, 3'b010));
        // starvation of requester 1 against the display
        tv.push_back(mk(0, 3'b011, 1, 2, 0, 3'b001, 0, 3'b100));
        tv.push_back(mk(0, 3'b011, 1, 2, 0, 3'b001, 0, 3'b000));
        tv.push_back(mk(0, 3'b011, 1, 2, 0, 3'b001, 0, 3'b001));
        tv.push_back(mk(0, 3'b011, 1, 2, 0, 3'b001, 0, 3'b001));
        tv.push_back(mk(0, 3'b011, 1, 2, 0, 3'b010, 1, 3'b001));
        tv.push_back(mk(0, 3'b011, 1, 2, 0, 3'b001, 0, 3'b001));
        tv.push_back(mk(0, 3'b000, 0, 0, 0, 3'b000, 0, 3'b010));
        // both gradients starve together
        tv.push_back(mk(0, 3'b111, 3, 4, 9, 3'b001, 0, 3'b001));
        tv.push_back(mk(0, 3'b111, 3, 4, 9, 3'b001, 0, 3'b000));
        tv.push_back(mk(0, 3'b111, 3, 4, 9, 3'b001, 0, 3'b001));
        tv.push_back(mk(0, 3'b111, 3, 4, 9, 3'b001, 0, 3'b001));
        tv.push_back(mk(0, 3'b111, 3, 4, 9, 3'b010, 1, 3'b001));
        tv.push_back(mk(0, 3'b111, 3, 4, 9, 3'b100, 1, 3'b001));
        tv.push_back(mk(0, 3'b111, 3, 4, 9, 3'b001, 0, 3'b010));
        tv.push_back(mk(0, 3'b000, 0, 0, 0, 3'b000, 0, 3'b100));
        // back-to-back reads at boundary addresses
        tv.push_back(mk(0, 3'b001, 0, 0, 0, 3'b001, 0, 3'b001));
        tv.push_back(mk(0, 3'b010, 0, 19199, 0, 3'b010, 0, 3'b000));
        tv.push_back(mk(0, 3'b100, 0, 0, 80, 3'b100, 0, 3'b001));
        tv.push_back(mk(0, 3'b000, 0, 0, 0, 3'b000, 0, 3'b010));
        tv.push_back(mk(0, 3'b000, 0, 0, 0, 3'b000, 0, 3'b100));
        // reset one cycle after a grant
        tv.push_back(mk(0, 3'b010, 0, 50, 0, 3'b010, 0, 3'b000));
        tv.push_back(mk(1, 3'b110, 0, 50, 60, 3'b000, 0, 3'b000));
        tv.push_back(mk(0, 3'b110, 0, 50, 60, 3'b010, 0, 3'b000));
        tv.push_back(mk(0, 3'b000, 0, 0, 0, 3'b000, 0, 3'b000));
        tv.push_back(mk(0, 3'b000, 0, 0, 0, 3'b000, 0, 3'b010));

        m_reset();
        set_in(1, 3'b000, 0, 0, 0);
        step();
        step();

        for (int i = 0; i < tv.size(); i++) begin
            int who;
            int ea;
            set_in(tv[i].rst, tv[i].req, tv[i].a0, tv[i].a1, tv[i].a2);
            ea = tv[i].g[0] ? tv[i].a0 :
                 tv[i].g[1] ? tv[i].a1 :
                 tv[i].g[2] ? tv[i].a2 : 0;
            @(negedge clk);
            chk($sformatf("t%0d_gnt", i), 32'(gnt), 32'(tv[i].g));
            chk($sformatf("t%0d_addr", i), 32'(fb_addr), ea);
            chk($sformatf("t%0d_starve", i), 32'(starve_evt),
                32'(tv[i].s));
            chk($sformatf("t%0d_rvalid", i), 32'(rvalid), 32'(tv[i].r));
            model_check(who);
            @(posedge clk);
            m_advance(who);
            #1;
        end

        // ---------------- randomized traffic ----------------
        for (int c = 0; c < 3000; c++) begin
            logic [2:0] q;
            q[0] = ($urandom % 10) < 6;
            q[1] = ($urandom % 10) < 7;
            q[2] = ($urandom % 10) < 7;
            set_in(($urandom % 150) == 0, q,
                   int'($urandom_range(0, 19199)),
                   int'($urandom_range(0, 19199)),
                   int'($urandom_range(0, 19199)));
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
